// File: rtl/periph_target_pkg.sv
// Shared definitions for the crossbar target adapter: error response payload,
// buffer entry layout helper and the request legality check.
package periph_target_pkg;

  localparam logic [31:0] ERR_RDATA = 32'hBADACCE5;

  typedef struct packed {
    logic done;
    logic opc;
  } entry_flags_t;

  function automatic logic err_check(input logic [5:0]  atop,
                                     input logic        atop_en,
                                     input logic [63:0] add,
                                     input logic [63:0] n_words);
    return ((!atop_en) && (atop != 6'd0)) || (add >= n_words);
  endfunction

endpackage

// File: rtl/periph_target_resp_buf.sv
// In-order response buffer: entries are pushed on accept, completed by local
// error or by the in-order backend response, and popped one per cycle.
module periph_target_resp_buf
  import periph_target_pkg::*;
#(
  parameter int ID_WIDTH   = 16,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic                  i_push_err,
  input  logic [ID_WIDTH-1:0]   i_push_id,
  input  logic                  i_fill,
  input  logic [DATA_WIDTH-1:0] i_fill_rdata,
  input  logic                  i_fill_opc,
  output logic                  o_full,
  output logic                  o_fill_miss,
  output logic                  o_r_valid,
  output logic [ID_WIDTH-1:0]   o_r_id,
  output logic [DATA_WIDTH-1:0] o_r_rdata,
  output logic                  o_r_opc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]      r_head, r_tail;
  logic [CNT_W-1:0]      r_count;
  logic [DEPTH-1:0]      r_done;
  logic [ID_WIDTH-1:0]   r_id    [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata [DEPTH];
  logic                  r_opc   [DEPTH];

  logic                  r_valid;
  logic [ID_WIDTH-1:0]   r_out_id;
  logic [DATA_WIDTH-1:0] r_out_rdata;
  logic                  r_out_opc;

  logic                  w_pend_found;
  logic [PTR_W-1:0]      w_pend_idx;
  logic                  w_fill_hit;
  logic                  w_pop;
  entry_flags_t          w_pop_flags;
  logic [DATA_WIDTH-1:0] w_pop_rdata;

  // Oldest live entry still waiting for the backend, searched from the head.
  always_comb begin
    w_pend_found = 1'b0;
    w_pend_idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (!w_pend_found && (CNT_W'(k) < r_count) && !r_done[r_head + PTR_W'(k)]) begin
        w_pend_found = 1'b1;
        w_pend_idx   = r_head + PTR_W'(k);
      end
    end
  end

  assign w_fill_hit  = i_fill & w_pend_found;
  assign o_fill_miss = i_fill & ~w_pend_found;
  assign o_full      = (r_count == CNT_W'(DEPTH));

  assign w_pop = (r_count != '0) &&
                 (r_done[r_head] || (w_fill_hit && (w_pend_idx == r_head)));
  assign w_pop_flags.done = 1'b1;
  assign w_pop_flags.opc  = r_done[r_head] ? r_opc[r_head]   : i_fill_opc;
  assign w_pop_rdata      = r_done[r_head] ? r_rdata[r_head] : i_fill_rdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_done      <= '0;
      r_valid     <= 1'b0;
      r_out_id    <= '0;
      r_out_rdata <= '0;
      r_out_opc   <= 1'b0;
    end else begin
      if (i_push) begin
        r_done[r_tail] <= i_push_err;
        r_tail         <= r_tail + PTR_W'(1);
      end
      if (w_fill_hit)
        r_done[w_pend_idx] <= 1'b1;
      if (w_pop)
        r_head <= r_head + PTR_W'(1);
      r_count <= r_count + CNT_W'(i_push) - CNT_W'(w_pop);
      r_valid <= w_pop;
      if (w_pop) begin
        r_out_id    <= r_id[r_head];
        r_out_rdata <= w_pop_rdata;
        r_out_opc   <= w_pop_flags.opc;
      end
    end
  end

  // Payload storage; a pushed entry carries the error payload until a fill replaces it.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_id[r_tail]    <= i_push_id;
      r_rdata[r_tail] <= DATA_WIDTH'(ERR_RDATA);
      r_opc[r_tail]   <= 1'b1;
    end
    if (w_fill_hit) begin
      r_rdata[w_pend_idx] <= i_fill_rdata;
      r_opc[w_pend_idx]   <= i_fill_opc;
    end
  end

  assign o_r_valid = r_valid;
  assign o_r_id    = r_out_id;
  assign o_r_rdata = r_out_rdata;
  assign o_r_opc   = r_out_opc;

endmodule

// File: rtl/periph_target_adapter.sv
// Crossbar slave-port endpoint: forwards legal requests to a grant-based
// backend, answers illegal ones locally and returns responses in order.
module periph_target_adapter
  import periph_target_pkg::*;
#(
  parameter int ADDR_WIDTH   = 30,
  parameter int DATA_WIDTH   = 32,
  parameter int BE_WIDTH     = DATA_WIDTH / 8,
  parameter int ID_WIDTH     = 16,
  parameter int N_WORDS      = 1024,
  parameter int DEPTH        = 4,
  parameter int ATOP_SUPPORT = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  data_req_i,
  input  logic [ADDR_WIDTH-1:0] data_add_i,
  input  logic                  data_wen_i,
  input  logic [5:0]            data_atop_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  input  logic [BE_WIDTH-1:0]   data_be_i,
  input  logic [ID_WIDTH-1:0]   data_ID_i,
  output logic                  data_gnt_o,
  output logic                  data_r_valid_o,
  output logic [ID_WIDTH-1:0]   data_r_ID_o,
  output logic [DATA_WIDTH-1:0] data_r_rdata_o,
  output logic                  data_r_opc_o,
  output logic                  bus_req_o,
  output logic [ADDR_WIDTH-1:0] bus_add_o,
  output logic                  bus_wen_o,
  output logic [DATA_WIDTH-1:0] bus_wdata_o,
  output logic [BE_WIDTH-1:0]   bus_be_o,
  input  logic                  bus_gnt_i,
  input  logic                  bus_r_valid_i,
  input  logic [DATA_WIDTH-1:0] bus_r_rdata_i,
  input  logic                  bus_r_opc_i,
  output logic                  unexp_resp_o
);

  logic w_err;
  logic w_full;
  logic w_open;
  logic w_fill_miss;
  logic r_unexp;

  assign w_err = err_check(data_atop_i, (ATOP_SUPPORT != 0),
                           64'(data_add_i), 64'(N_WORDS));

  // Held low during reset so nothing is accepted into a buffer being cleared.
  assign w_open     = rst_n & data_req_i & ~w_full;
  assign bus_req_o  = w_open & ~w_err;
  assign data_gnt_o = w_open & (w_err | bus_gnt_i);

  assign bus_add_o   = data_add_i;
  assign bus_wen_o   = data_wen_i;
  assign bus_wdata_o = data_wdata_i;
  assign bus_be_o    = data_be_i;

  periph_target_resp_buf #(
    .ID_WIDTH   (ID_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_resp_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_push       (data_gnt_o),
    .i_push_err   (w_err),
    .i_push_id    (data_ID_i),
    .i_fill       (bus_r_valid_i),
    .i_fill_rdata (bus_r_rdata_i),
    .i_fill_opc   (bus_r_opc_i),
    .o_full       (w_full),
    .o_fill_miss  (w_fill_miss),
    .o_r_valid    (data_r_valid_o),
    .o_r_id       (data_r_ID_o),
    .o_r_rdata    (data_r_rdata_o),
    .o_r_opc      (data_r_opc_o)
  );

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_unexp <= 1'b0;
    else if (w_fill_miss)
      r_unexp <= 1'b1;
  end

  assign unexp_resp_o = r_unexp;

endmodule

// File: tb/tb_periph_target_adapter.sv
// Directed scoreboard bench for periph_target_adapter with default parameters.
module tb_periph_target_adapter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        data_req_i;
  logic [29:0] data_add_i;
  logic        data_wen_i;
  logic [5:0]  data_atop_i;
  logic [31:0] data_wdata_i;
  logic [3:0]  data_be_i;
  logic [15:0] data_ID_i;
  logic        data_gnt_o;
  logic        data_r_valid_o;
  logic [15:0] data_r_ID_o;
  logic [31:0] data_r_rdata_o;
  logic        data_r_opc_o;
  logic        bus_req_o;
  logic [29:0] bus_add_o;
  logic        bus_wen_o;
  logic [31:0] bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_gnt_i;
  logic        bus_r_valid_i;
  logic [31:0] bus_r_rdata_i;
  logic        bus_r_opc_i;
  logic        unexp_resp_o;

  typedef struct packed {
    logic [15:0] id;
    logic [31:0] rdata;
    logic        opc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  periph_target_adapter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_req_i     (data_req_i),
    .data_add_i     (data_add_i),
    .data_wen_i     (data_wen_i),
    .data_atop_i    (data_atop_i),
    .data_wdata_i   (data_wdata_i),
    .data_be_i      (data_be_i),
    .data_ID_i      (data_ID_i),
    .data_gnt_o     (data_gnt_o),
    .data_r_valid_o (data_r_valid_o),
    .data_r_ID_o    (data_r_ID_o),
    .data_r_rdata_o (data_r_rdata_o),
    .data_r_opc_o   (data_r_opc_o),
    .bus_req_o      (bus_req_o),
    .bus_add_o      (bus_add_o),
    .bus_wen_o      (bus_wen_o),
    .bus_wdata_o    (bus_wdata_o),
    .bus_be_o       (bus_be_o),
    .bus_gnt_i      (bus_gnt_i),
    .bus_r_valid_i  (bus_r_valid_i),
    .bus_r_rdata_i  (bus_r_rdata_i),
    .bus_r_opc_i    (bus_r_opc_i),
    .unexp_resp_o   (unexp_resp_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [15:0] id, input logic [29:0] add, input logic [5:0] atop);
    data_req_i   = 1'b1;
    data_ID_i    = id;
    data_add_i   = add;
    data_atop_i  = atop;
    data_wen_i   = 1'b1;
    data_wdata_i = 32'h0;
    data_be_i    = 4'hF;
  endtask

  task automatic push_exp(input logic [15:0] id, input logic [31:0] rdata, input logic opc);
    exp_t e;
    e.id    = id;
    e.rdata = rdata;
    e.opc   = opc;
    exp_q.push_back(e);
  endtask

  // Monitor: every presented response must match the oldest expected one.
  always @(negedge clk) begin
    if (data_r_valid_o === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL resp_unexpected: got id=%h rdata=%h opc=%b expected no response",
                 data_r_ID_o, data_r_rdata_o, data_r_opc_o);
      end else begin
        mon_e = exp_q.pop_front();
        if ({data_r_ID_o, data_r_rdata_o, data_r_opc_o} !== mon_e) begin
          bad++;
          $display("FAIL resp_data: got id=%h rdata=%h opc=%b expected id=%h rdata=%h opc=%b",
                   data_r_ID_o, data_r_rdata_o, data_r_opc_o, mon_e.id, mon_e.rdata, mon_e.opc);
        end
      end
    end
  end

  initial begin
    rst_n         = 1'b0;
    bus_gnt_i     = 1'b1;
    bus_r_valid_i = 1'b0;
    bus_r_rdata_i = 32'h0;
    bus_r_opc_i   = 1'b0;
    drive_req(16'h0001, 30'd5, 6'd0);
    #2;
    chk("rst_gnt", 64'(data_gnt_o), 64'd0);
    chk("rst_bus_req", 64'(bus_req_o), 64'd0);
    tick();
    tick();
    chk("rst_valid", 64'(data_r_valid_o), 64'd0);
    chk("rst_id", 64'(data_r_ID_o), 64'd0);
    chk("rst_rdata", 64'(data_r_rdata_o), 64'd0);
    chk("rst_opc", 64'(data_r_opc_o), 64'd0);
    chk("rst_unexp", 64'(unexp_resp_o), 64'd0);
    data_req_i = 1'b0;
    rst_n = 1'b1;
    tick();

    // Single legal load, backend answers two cycles after accept.
    drive_req(16'h0004, 30'd5, 6'd0);
    #1;
    chk("ld_gnt", 64'(data_gnt_o), 64'd1);
    chk("ld_bus_req", 64'(bus_req_o), 64'd1);
    chk("ld_bus_add", 64'(bus_add_o), 64'd5);
    chk("ld_bus_be", 64'(bus_be_o), 64'hF);
    push_exp(16'h0004, 32'h1234, 1'b0);
    tick();
    data_req_i = 1'b0;
    tick();
    chk("ld_wait", 64'(data_r_valid_o), 64'd0);
    bus_r_valid_i = 1'b1;
    bus_r_rdata_i = 32'h1234;
    tick();
    bus_r_valid_i = 1'b0;
    chk("ld_lat", 64'(data_r_valid_o), 64'd1);
    chk("ld_id", 64'(data_r_ID_o), 64'h0004);
    tick();

    // Atomic request answered locally.
    drive_req(16'h0001, 30'd3, 6'h21);
    #1;
    chk("atop_gnt", 64'(data_gnt_o), 64'd1);
    chk("atop_bus_req", 64'(bus_req_o), 64'd0);
    push_exp(16'h0001, 32'hBADACCE5, 1'b1);
    tick();
    data_req_i = 1'b0;
    chk("atop_t1", 64'(data_r_valid_o), 64'd0);
    tick();
    chk("atop_t2", 64'(data_r_valid_o), 64'd1);
    tick();

    // Out-of-range error queued behind a pending load.
    drive_req(16'h0001, 30'd10, 6'd0);
    push_exp(16'h0001, 32'h0000CAFE, 1'b0);
    tick();
    drive_req(16'h0002, 30'd1024, 6'd0);
    #1;
    chk("oor_gnt", 64'(data_gnt_o), 64'd1);
    chk("oor_bus_req", 64'(bus_req_o), 64'd0);
    push_exp(16'h0002, 32'hBADACCE5, 1'b1);
    tick();
    data_req_i = 1'b0;
    tick();
    tick();
    chk("ord_hold", 64'(data_r_valid_o), 64'd0);
    bus_r_valid_i = 1'b1;
    bus_r_rdata_i = 32'h0000CAFE;
    tick();
    bus_r_valid_i = 1'b0;
    chk("ord_first", 64'({data_r_valid_o, data_r_ID_o}), 64'h1_0001);
    tick();
    chk("ord_second", 64'({data_r_valid_o, data_r_ID_o}), 64'h1_0002);
    tick();
    chk("ord_idle", 64'(data_r_valid_o), 64'd0);

    // Fill to DEPTH, then one response frees exactly one slot next cycle.
    for (int i = 0; i < 4; i++) begin
      drive_req(16'(1 << i), 30'(20 + i), 6'd0);
      #1;
      chk("fill_gnt", 64'(data_gnt_o), 64'd1);
      push_exp(16'(1 << i), 32'hA0 + 32'(i), 1'b0);
      tick();
    end
    drive_req(16'h0010, 30'd24, 6'd0);
    #1;
    chk("full_gnt", 64'(data_gnt_o), 64'd0);
    chk("full_bus_req", 64'(bus_req_o), 64'd0);
    tick();
    bus_r_valid_i = 1'b1;
    bus_r_rdata_i = 32'hA0;
    #1;
    chk("full_same_cycle", 64'(data_gnt_o), 64'd0);
    tick();
    bus_r_valid_i = 1'b0;
    chk("full_next", 64'(data_gnt_o), 64'd1);
    push_exp(16'h0010, 32'hA4, 1'b0);
    tick();
    data_req_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      bus_r_valid_i = 1'b1;
      bus_r_rdata_i = 32'hA0 + 32'(i);
      tick();
      chk("b2b_valid", 64'(data_r_valid_o), 64'd1);
    end
    bus_r_valid_i = 1'b0;
    tick();
    chk("b2b_idle", 64'(data_r_valid_o), 64'd0);

    // Backend stalls grant for three cycles.
    drive_req(16'h0020, 30'd7, 6'd0);
    bus_gnt_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_gnt", 64'(data_gnt_o), 64'd0);
      chk("stall_bus_req", 64'(bus_req_o), 64'd1);
      tick();
    end
    bus_gnt_i = 1'b1;
    #1;
    chk("stall_release", 64'(data_gnt_o), 64'd1);
    push_exp(16'h0020, 32'h77, 1'b0);
    tick();
    data_req_i = 1'b0;
    tick();
    bus_r_valid_i = 1'b1;
    bus_r_rdata_i = 32'h77;
    tick();
    bus_r_valid_i = 1'b0;
    chk("stall_resp", 64'(data_r_valid_o), 64'd1);
    tick();

    // Reset with two requests outstanding; their late responses are unexpected.
    drive_req(16'h0040, 30'd8, 6'd0);
    tick();
    drive_req(16'h0080, 30'd9, 6'd0);
    tick();
    data_req_i = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_unexp", 64'(unexp_resp_o), 64'd0);
    chk("mid_rst_valid", 64'(data_r_valid_o), 64'd0);
    bus_r_valid_i = 1'b1;
    bus_r_rdata_i = 32'h55;
    tick();
    tick();
    bus_r_valid_i = 1'b0;
    chk("unexp_set", 64'(unexp_resp_o), 64'd1);
    tick();
    tick();
    tick();
    chk("unexp_sticky", 64'(unexp_resp_o), 64'd1);
    chk("unexp_no_valid", 64'(data_r_valid_o), 64'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("unexp_cleared", 64'(unexp_resp_o), 64'd0);
    tick();

    chk("drain", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
